// File: rtl/noc_pkg.sv
// Shared router definitions: flit sizing, port indices and the one-hot
// encodings shared by the input buffers, handshakes and arbiters.
package noc_pkg;

    localparam int FLIT_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_PORTS  = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_W = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        CTS_IDLE = 2'b01,
        CTS_ACK  = 2'b10
    } cts_state_e;

    localparam logic [NUM_PORTS-1:0] XBAR_SEL_N = 5'b00001;
    localparam logic [NUM_PORTS-1:0] XBAR_SEL_E = 5'b00010;
    localparam logic [NUM_PORTS-1:0] XBAR_SEL_W = 5'b00100;
    localparam logic [NUM_PORTS-1:0] XBAR_SEL_S = 5'b01000;
    localparam logic [NUM_PORTS-1:0] XBAR_SEL_L = 5'b10000;

    // True when two or more bits of a port request vector are set.
    function automatic logic multi_hot(input logic [NUM_PORTS-1:0] v);
        return (v & (v - NUM_PORTS'(1))) != '0;
    endfunction

endpackage

// File: rtl/noc_input_fifo_if.sv
// Per-port buffer bus: upstream DRTS/CTS handshake, arbiter pop requests
// and the head-flit/status view.
import noc_pkg::*;

interface noc_input_fifo_if #(
    parameter int DATA_WIDTH = FLIT_WIDTH
);
    logic [DATA_WIDTH-1:0] RX;
    logic                  DRTS;
    logic                  CTS;
    logic                  read_en_N;
    logic                  read_en_E;
    logic                  read_en_W;
    logic                  read_en_S;
    logic                  read_en_L;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;
    logic                  err_multi_read;

    modport master (
        output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, Data_out, empty, full, err_multi_read
    );

    modport slave (
        input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, Data_out, empty, full, err_multi_read
    );
endinterface

// File: rtl/noc_cts_handshake.sv
// Two-state CTS machine: accepts one flit per DRTS request when not full,
// answering with a single-cycle registered CTS pulse.
import noc_pkg::*;

module noc_cts_handshake (
    input  logic clk,
    input  logic rst,
    input  logic DRTS,
    input  logic full,
    output logic CTS,
    output logic wr_fire
);
    cts_state_e state_q, state_d;

    always_comb begin
        wr_fire = (state_q == CTS_IDLE) && DRTS && !full;
        state_d = wr_fire ? CTS_ACK : CTS_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign CTS = (state_q == CTS_ACK);
endmodule

// File: rtl/noc_input_fifo.sv
// Router input-port FIFO: first-word-fall-through head flit, popped by any
// output arbiter grant, filled through the CTS handshake.
import noc_pkg::*;

module noc_input_fifo #(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input logic              clk,
    input logic              rst,
    noc_input_fifo_if.slave  bus
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  err_q, err_d;
    logic [NUM_PORTS-1:0]  rd_req;
    logic                  empty_w, full_w, pop, wr_fire;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_FULL);

    noc_cts_handshake u_cts (
        .clk     (clk),
        .rst     (rst),
        .DRTS    (bus.DRTS),
        .full    (full_w),
        .CTS     (bus.CTS),
        .wr_fire (wr_fire)
    );

    always_comb begin
        rd_req         = '0;
        rd_req[PORT_N] = bus.read_en_N;
        rd_req[PORT_E] = bus.read_en_E;
        rd_req[PORT_W] = bus.read_en_W;
        rd_req[PORT_S] = bus.read_en_S;
        rd_req[PORT_L] = bus.read_en_L;
        pop            = (|rd_req) && !empty_w;

        wr_ptr_d = wr_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        err_d    = err_q || multi_hot(rd_req);

        count_d = count_q;
        case ({wr_fire, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset; reset only gates the write.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            mem_q[wr_ptr_q] <= bus.RX;
        end
    end

    assign bus.Data_out       = mem_q[rd_ptr_q];
    assign bus.empty          = empty_w;
    assign bus.full           = full_w;
    assign bus.err_multi_read = err_q;
endmodule

// File: doc/noc_input_fifo.md
Name: noc_input_fifo

Overview:
- Per-port input buffer of the 5-port mesh router, one instance per input port (N, E, W, S, L).
- Sits directly upstream of the round-robin arbiters:
  - Accepts flits from the neighbouring router or the local PE over the DRTS/CTS handshake.
  - Presents the head flit combinationally to route computation and the crossbar.
  - Pops the head flit when one of the five output arbiters grants this port.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, number of flit slots; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- RX  in  DATA_WIDTH  incoming flit; valid when DRTS=1.
- DRTS  in  1  upstream request-to-send.
- CTS  out  1  clear-to-send back to upstream (registered).
- read_en_N  in  1  pop request from the North output arbiter grant.
- read_en_E  in  1  pop request from the East output arbiter grant.
- read_en_W  in  1  pop request from the West output arbiter grant.
- read_en_S  in  1  pop request from the South output arbiter grant.
- read_en_L  in  1  pop request from the Local output arbiter grant.
- Data_out  out  DATA_WIDTH  head flit, first-word-fall-through.
- empty  out  1  no flit stored.
- full  out  1  DEPTH flits stored.
- err_multi_read  out  1  sticky: more than one read_en seen in one cycle.

Behaviour:
- Reset (rst=1 at posedge clk): wr_ptr=0, rd_ptr=0, count=0, CTS=0, err_multi_read=0.
  - Outputs after reset: empty=1, full=0.
  - Data_out is don't-care while empty; storage is not cleared.
- Handshake, a two-state CTS machine:
  - IDLE (CTS=0) -> ACK (CTS=1) at the next edge when DRTS=1 and full=0.
  - ACK -> IDLE unconditionally at the next edge. CTS is therefore a single-cycle pulse per flit.
  - In IDLE, DRTS=1 with full=1 leaves CTS=0; the flit is held upstream until space frees.
- Write: on the same edge that moves IDLE->ACK, RX is stored at mem[wr_ptr] and wr_ptr increments.
  - Upstream must hold RX and DRTS stable until it sees CTS=1.
- Read:
  - pop = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty.
  - On pop, rd_ptr increments at the edge.
  - A pop while empty is ignored; no pointer movement, no error flag.
- Data_out = mem[rd_ptr] combinationally.
  - A flit written at edge k is visible on Data_out after edge k, with empty=0.
  - Write-to-read latency is 1 cycle.
- Pointer wrap: modulo DEPTH via natural PTR_W-bit overflow.
- count arithmetic:
  - count is PTR_W+1 bits wide, giving range 0..DEPTH.
  - count is +1 on write only, -1 on pop only, and unchanged on both or neither.
- Status flags: full = (count==DEPTH); empty = (count==0).
- Simultaneous events:
  - Write and pop in the same cycle when not full: both take effect and count is unchanged.
  - When full, the write is blocked in that cycle even if a pop occurs. The full check uses pre-edge state, so there is no write-through.
  - Write and pop when count=1: the old head is popped, and the new flit becomes head after the edge.
- err_multi_read:
  - Set when two or more read_en inputs are high in the same cycle, regardless of empty.
  - Cleared only by rst.
  - Pop still happens exactly once in that cycle.
- Reset mid-operation: rst has priority over all writes and pops. Any in-flight CTS pulse is cancelled (CTS=0 after the edge).

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_WIDTH=32 and default FIFO_DEPTH=4.
  - Port index enum {PORT_N, PORT_E, PORT_W, PORT_S, PORT_L}.
  - The one-hot state/Xbar_sel encodings shared with the arbiter.
- One natural sub-module: noc_cts_handshake, containing the IDLE/ACK machine.
  - Inputs: DRTS, full.
  - Outputs: CTS, wr_fire.
  - Reused on the router's output side.

Test Plan:
- Reset then single flit: rst 2 cycles; DRTS=1, RX=32'hA5A5_0001 -> CTS=1 one cycle later, then 0; empty=0 and Data_out=32'hA5A5_0001; read_en_E=1 for 1 cycle -> empty=1.
- Fill to full:
  - Push 4 flits 32'h1..32'h4 -> full=1, CTS stays 0 with DRTS held high on a 5th flit 32'h5.
  - Assert read_en_N for 1 cycle -> CTS pulses 1 the following cycle and 32'h5 is accepted.
  - Drain order is 1,2,3,4,5.
- Simultaneous push/pop at count=2: count stays 2 and Data_out advances to the next flit. Run 12 flits through to cover pointer wrap; no loss, order preserved.
- Pop while empty: read_en_L=1 with empty=1 -> pointers unchanged, empty stays 1, err_multi_read stays 0.
- Multi-read error: 2 flits stored; read_en_N=1 and read_en_S=1 in the same cycle -> exactly one flit popped (empty=0, Data_out = 2nd flit), err_multi_read=1 and stays 1 until rst.
- Reset mid-transfer: rst asserted on the cycle CTS=1 with 3 flits stored -> after the edge CTS=0, empty=1, full=0, err_multi_read=0.
